// File: rtl/wb_pkg.sv
// Shared definitions for the CPU-to-Wishbone master bridge.
package wb_pkg;

  // Bridge FSM: wait for a request, run one bus cycle, report completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam logic [31:0] GPIO_BASE          = 32'h0000_7F00;
  localparam int unsigned WB_TIMEOUT_DEFAULT = 16;
  localparam logic [31:0] WB_ERR_RDATA       = 32'h0000_0000;

endpackage

// File: rtl/wb_master_bridge.sv
// CPU load/store port to Wishbone classic single-beat master, with ack timeout.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = WB_TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_RDATA = WB_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_gnt_o,
  output logic        cpu_done_o,
  output logic        cpu_err_o,
  output logic [31:0] cpu_rdata_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);

  wb_state_e     state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  // Next-state and registered-output decode. cyc/done are computed for the
  // state being entered so they appear in the same cycle as that state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    cyc_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          we_d    = cpu_we_i;
          if (cpu_addr_i[1:0] != 2'b00) begin
            // Misaligned: complete with error, never touch the bus.
            state_d = ST_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
          end else begin
            state_d = ST_BUS;
            cnt_d   = '0;
            cyc_d   = 1'b1;
          end
        end
      end
      ST_BUS: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (wb_ack_i) begin
          // Ack beats timeout even on the last allowed cycle.
          state_d = ST_RESP;
          done_d  = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : wb_dat_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end else begin
          cyc_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latches and registered outputs; reset aborts any cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_gnt_o   = (state_q == ST_IDLE);
  assign cpu_done_o  = done_q;
  assign cpu_err_o   = err_q;
  assign cpu_rdata_o = rdata_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_adr_o    = addr_q;
  assign wb_dat_o    = wdata_q;
  assign wb_we_o     = we_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench: expected per-cycle timeline built per transaction, compared every cycle.
module tb_wb_master_bridge;
  import wb_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic        cpu_gnt_o, cpu_done_o, cpu_err_o;
  logic [31:0] cpu_rdata_o, wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic        wb_ack_i = 1'b0;

  wb_master_bridge #(.TIMEOUT(TO), .ERR_RDATA(WB_ERR_RDATA)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o), .cpu_done_o(cpu_done_o),
    .cpu_err_o(cpu_err_o), .cpu_rdata_o(cpu_rdata_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // One expected cycle of observable behaviour.
  typedef struct {
    logic        cyc;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  function automatic exp_t mk(logic cyc, logic done, logic err, logic [31:0] rdata,
                              logic we, logic [31:0] adr, logic [31:0] dat);
    exp_t e;
    e.cyc = cyc; e.done = done; e.err = err; e.rdata = rdata;
    e.we = we; e.adr = adr; e.dat = dat;
    return e;
  endfunction

  exp_t q[$];

  // Simple slave: ack after slv_wait wait states of the current cycle (-1 = never).
  int          slv_wait = -1;
  int          slv_cnt = 0;
  logic [31:0] slv_rdata = '0;
  logic        stray_ack = 1'b0;
  assign wb_dat_i = wb_ack_i ? slv_rdata : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    #1;
    if (wb_cyc_o) begin
      wb_ack_i = (slv_cnt == slv_wait);
      slv_cnt++;
    end else begin
      wb_ack_i = stray_ack;
      slv_cnt = 0;
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // Compare process: every cycle against the expected timeline (idle when empty).
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;
  int          cyc_cycles = 0, cyc_rises = 0, done_at = 0;
  logic        cyc_prev = 1'b0;

  always @(negedge clk) begin : cmp
    exp_t e;
    if (!rst_n) begin
      q.delete();
      last_err = 1'b0;
      last_rdata = '0;
    end
    if (q.size() > 0) e = q.pop_front();
    else e = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    if (e.done) begin
      last_err = e.err;
      last_rdata = e.rdata;
      done_at = cyc_n;
    end
    chk1("gnt", cpu_gnt_o, !e.cyc && !e.done);
    chk1("cyc", wb_cyc_o, e.cyc);
    chk1("stb", wb_stb_o, e.cyc);
    chk1("done", cpu_done_o, e.done);
    chk1("err", cpu_err_o, last_err);
    chk("rdata", cpu_rdata_o, last_rdata);
    if (e.cyc) begin
      chk("wb_adr", wb_adr_o, e.adr);
      chk("wb_dat", wb_dat_o, e.dat);
      chk1("wb_we", wb_we_o, e.we);
    end
    if (wb_cyc_o) cyc_cycles++;
    if (wb_cyc_o && !cyc_prev) cyc_rises++;
    cyc_prev = wb_cyc_o;
  end

  // Issue one request from the start of an idle cycle; returns at the start of
  // the next idle cycle. Expected timeline follows from wait states and TIMEOUT.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input int wt, input logic [31:0] rd, input bit keep, output int grant_cyc);
    int n;
    bit to;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = adr; cpu_wdata_i = dat;
    slv_wait = wt; slv_rdata = rd;
    grant_cyc = cyc_n;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
    if (adr[1:0] != 2'b00) begin
      n = 0; to = 1'b1;
    end else begin
      if (wt < 0 || wt >= TO) begin n = TO; to = 1'b1; end
      else begin n = wt + 1; to = 1'b0; end
      for (int i = 0; i < n; i++) q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, we, adr, dat));
    end
    q.push_back(mk(1'b0, 1'b1, to, to ? WB_ERR_RDATA : (we ? 32'h0 : rd), 1'b0, 32'h0, 32'h0));
    @(posedge clk); #1;
    if (!keep) cpu_req_i = 1'b0;
    repeat (n + 1) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int g, g2;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_gnt", cpu_gnt_o, 1'b1);
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk1("rst_done", cpu_done_o, 1'b0);
    chk("rst_rdata", cpu_rdata_o, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Zero-wait write to GPIO
    cyc_cycles = 0;
    xfer(1'b1, GPIO_BASE, 32'h1234_5678, 0, 32'h0, 1'b0, g);
    chk("wr_cyc_cycles", cyc_cycles, 1);
    chk("wr_latency", done_at - g, 2);
    chk1("wr_err", cpu_err_o, 1'b0);
    idle(1);

    // Read with 2 wait states
    xfer(1'b0, GPIO_BASE, 32'h0, 2, 32'hA5A5_A5A5, 1'b0, g);
    chk("rd_latency", done_at - g, 4);
    chk("rd_rdata", cpu_rdata_o, 32'hA5A5_A5A5);
    chk1("rd_err", cpu_err_o, 1'b0);

    // Dead slave: full timeout
    cyc_cycles = 0;
    xfer(1'b0, GPIO_BASE + 32'h4, 32'h0, -1, 32'h0, 1'b0, g);
    chk("to_cyc_cycles", cyc_cycles, TO);
    chk("to_latency", done_at - g, TO + 1);
    chk1("to_err", cpu_err_o, 1'b1);
    chk("to_rdata", cpu_rdata_o, 32'h0);

    // Ack on the final allowed cycle wins
    cyc_cycles = 0;
    xfer(1'b0, GPIO_BASE + 32'h8, 32'h0, TO - 1, 32'hCAFE_0016, 1'b0, g);
    chk("ack16_cyc_cycles", cyc_cycles, TO);
    chk1("ack16_err", cpu_err_o, 1'b0);
    chk("ack16_rdata", cpu_rdata_o, 32'hCAFE_0016);

    // Misaligned read: no bus activity
    cyc_cycles = 0;
    xfer(1'b0, 32'h0000_7F02, 32'h0, 0, 32'h1111_1111, 1'b0, g);
    chk("mis_cyc_cycles", cyc_cycles, 0);
    chk("mis_latency", done_at - g, 1);
    chk1("mis_err", cpu_err_o, 1'b1);

    // Stray acks while idle are ignored
    stray_ack = 1'b1;
    idle(3);
    stray_ack = 1'b0;
    idle(1);

    // Back-to-back writes with request held high
    cyc_rises = 0;
    xfer(1'b1, GPIO_BASE, 32'hAAAA_0001, 0, 32'h0, 1'b1, g);
    xfer(1'b1, GPIO_BASE + 32'h4, 32'hBBBB_0002, 1, 32'h0, 1'b0, g2);
    chk("b2b_cycles", cyc_rises, 2);
    chk("b2b_gap", g2 - g, 3);
    idle(1);

    // Reset in the second BUS cycle of a wait-stated read
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = GPIO_BASE; cpu_wdata_i = 32'h0;
    slv_wait = 5; slv_rdata = 32'h5555_AAAA;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, GPIO_BASE, 32'h0));
    @(posedge clk); #1;
    cpu_req_i = 1'b0;
    @(posedge clk); #1;
    chk1("pre_rst_cyc", wb_cyc_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("arst_cyc", wb_cyc_o, 1'b0);
    chk1("arst_stb", wb_stb_o, 1'b0);
    chk1("arst_done", cpu_done_o, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk1("post_rst_gnt", cpu_gnt_o, 1'b1);
    xfer(1'b0, GPIO_BASE + 32'hC, 32'h0, 1, 32'h0BAD_F00D, 1'b0, g);
    chk("post_rst_rdata", cpu_rdata_o, 32'h0BAD_F00D);
    chk("post_rst_latency", done_at - g, 3);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Bridges the CPU's simple load/store request port to a Wishbone classic-cycle master. It sits directly upstream of the Wishbone peripherals (GPIO slave at 0x0000_7F00 and others) and drives their `wb_*` inputs. Each accepted CPU request produces exactly one single-beat Wishbone cycle. A bounded ack timeout ensures a dead slave can never hang the CPU.

## Interface
- `TIMEOUT`, default 16: maximum cycles `wb_cyc_o` stays high without `wb_ack_i`; legal range 2..255.
- `ERR_RDATA`, default 32'h0000_0000: value returned on `cpu_rdata_o` for any error completion.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req_i`  in  1  request valid; sampled only while `cpu_gnt_o`=1.
- `cpu_we_i`  in  1  1 = write, 0 = read.
- `cpu_addr_i`  in  32  byte address.
- `cpu_wdata_i`  in  32  write data.
- `cpu_gnt_o`  out  1  bridge idle; request accepted this cycle if `cpu_req_i`=1.
- `cpu_done_o`  out  1  one-cycle completion pulse.
- `cpu_err_o`  out  1  qualifies `cpu_done_o`: misaligned address or timeout.
- `cpu_rdata_o`  out  32  read data; valid when `cpu_done_o`=1.
- `wb_adr_o`  out  32  Wishbone address.
- `wb_dat_o`  out  32  Wishbone write data.
- `wb_dat_i`  in  32  Wishbone read data.
- `wb_we_o`  out  1  Wishbone write enable.
- `wb_stb_o`  out  1  Wishbone strobe.
- `wb_cyc_o`  out  1  Wishbone cycle.
- `wb_ack_i`  in  1  Wishbone acknowledge.

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE:** `cpu_gnt_o`=1. On `cpu_req_i`=1, latch `addr`/`wdata`/`we`.
  - If `addr[1:0]`≠0: go to RESP with err=1, no bus cycle.
  - Otherwise: go to BUS, clear the timeout counter.
- **BUS:** `wb_cyc_o`=`wb_stb_o`=1. `wb_adr_o`, `wb_dat_o`, `wb_we_o` come from the latches and are stable for the whole cycle. The counter increments every cycle.
  - `wb_ack_i`=1: capture `wb_dat_i` (reads only; writes return 0), err=0, go to RESP.
  - Else, counter = `TIMEOUT`-1: err=1, rdata=`ERR_RDATA`, go to RESP.
  - Ack on the final timeout cycle: ack wins and the transfer succeeds.
- **RESP:** `cpu_done_o`=1 for exactly one cycle with `cpu_err_o`/`cpu_rdata_o`, then go to IDLE. `wb_cyc_o`/`wb_stb_o`=0.
- `wb_ack_i` outside BUS is ignored.
- `cpu_req_i` outside IDLE is ignored. The CPU holds or re-asserts the request until it is granted.
- Reset values:
  - State IDLE, `cpu_gnt_o`=1.
  - All other outputs 0.
  - Latches and counter 0.
- Reset asserted mid-cycle: `wb_cyc_o`/`wb_stb_o` drop asynchronously and no `cpu_done_o` is issued for the aborted request.
- Counter width: $clog2(`TIMEOUT`+1) bits. It saturates and never wraps.

## Timing
- All outputs are registered except `cpu_gnt_o`, which decodes state==IDLE from registered state.
- Request accepted at edge E0 → `wb_cyc_o`/`wb_stb_o` high from E0.
- Single-cycle slave asserts ack during cycle E0..E1 → `cpu_done_o` high during E1..E2.
- Minimum request-to-done latency: 2 cycles.
- Zero-wait-state throughput: one transfer per 3 cycles (IDLE, BUS, RESP).
- Timeout: `wb_cyc_o` high for exactly `TIMEOUT` cycles, then `cpu_done_o` with err=1 the following cycle.
- Misaligned request: `cpu_done_o` with err=1 one cycle after acceptance; `wb_cyc_o` never rises.
- `cpu_rdata_o`/`cpu_err_o` hold their values until the next `cpu_done_o`.

## Structure
- Shared package `wb_pkg`:
  - FSM state enum (IDLE, BUS, RESP).
  - `GPIO_BASE` = 32'h0000_7F00.
  - `WB_TIMEOUT_DEFAULT` = 16.
  - `WB_ERR_RDATA` = 32'h0.
- No sub-module. The counter and FSM are small enough to live in one file.

## Test plan
- Write 0x12345678 to 0x7F00, slave acks in the first BUS cycle:
  - `wb_cyc_o` high exactly 1 cycle with `wb_we_o`=1 and `wb_dat_o`=0x12345678.
  - `cpu_done_o` 2 cycles after grant, err=0.
- Read 0x7F00, slave returns 0xA5A5A5A5 with 2 wait states → `cpu_rdata_o`=0xA5A5A5A5 and err=0 after 4 cycles.
- Slave never acks, `TIMEOUT`=16:
  - `wb_cyc_o` high exactly 16 cycles, then drops.
  - `cpu_done_o` with err=1 and rdata=0x0.
  - Repeat with ack on cycle 16: success, err=0.
- Read 0x7F02 (misaligned) → no Wishbone activity; `cpu_done_o`, err=1 one cycle after grant.
- `cpu_req_i` held high for two back-to-back writes → second grant in the cycle after the first `cpu_done_o`; exactly two Wishbone cycles.
- Assert `rst_n`=0 in the second BUS cycle of a wait-stated read → `wb_cyc_o`/`wb_stb_o` drop immediately, no `cpu_done_o`; after release `cpu_gnt_o`=1 and a new read completes normally.
